// File: rtl/bp_pkg.sv
// Shared definitions for the belief-propagation LLR update block:
// FSM state encoding and symmetric saturation limits.
package bp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int LLR_MAX(input int bit_n);
    return (1 << (bit_n - 1)) - 1;
  endfunction

  // Symmetric range: the most negative code is never produced
  function automatic int LLR_MIN(input int bit_n);
    return -LLR_MAX(bit_n);
  endfunction

endpackage

// File: rtl/llr_sat_add.sv
// Combinational symmetric saturating adder for two's-complement LLRs.
// The asymmetric minimum code on either input is folded to -LLR_MAX first.
module llr_sat_add
  import bp_pkg::*;
#(
  parameter int BIT_N = 8
) (
  input  logic signed [BIT_N-1:0] a,
  input  logic signed [BIT_N-1:0] b,
  output logic signed [BIT_N-1:0] sum
);

  localparam logic signed [BIT_N:0]   MAX_W    = (BIT_N+1)'(LLR_MAX(BIT_N));
  localparam logic signed [BIT_N:0]   MIN_W    = (BIT_N+1)'(LLR_MIN(BIT_N));
  localparam logic signed [BIT_N-1:0] MIN_N    = BIT_N'(LLR_MIN(BIT_N));
  localparam logic signed [BIT_N-1:0] NEG_EDGE = {1'b1, {(BIT_N-1){1'b0}}};

  logic signed [BIT_N-1:0] a_c;
  logic signed [BIT_N-1:0] b_c;
  logic signed [BIT_N:0]   wide;

  always_comb begin
    a_c  = (a == NEG_EDGE) ? MIN_N : a;
    b_c  = (b == NEG_EDGE) ? MIN_N : b;
    wide = {a_c[BIT_N-1], a_c} + {b_c[BIT_N-1], b_c};
    if (wide > MAX_W) begin
      sum = MAX_W[BIT_N-1:0];
    end else if (wide < MIN_W) begin
      sum = MIN_W[BIT_N-1:0];
    end else begin
      sum = wide[BIT_N-1:0];
    end
  end

endmodule

// File: rtl/bp_llr_update.sv
// Variable-node LLR update: latches the channel LLR per codeword, adds each
// incoming extrinsic message, and stops early once hard decisions settle.
module bp_llr_update
  import bp_pkg::*;
#(
  parameter int BIT_N      = 8,
  parameter int MAX_ITER   = 16,
  parameter int STABLE_CNT = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             start,
  input  logic [BIT_N-1:0]                 LLR_CH,
  input  logic                             msg_valid,
  input  logic [BIT_N-1:0]                 MSG_IN,
  output logic [BIT_N-1:0]                 OUT,
  output logic                             out_valid,
  output logic                             hard_bit,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(MAX_ITER+1)-1:0]    iter_cnt
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int SW = $clog2(STABLE_CNT + 1);

  state_t           state_q, state_d;
  logic [BIT_N-1:0] llr_q, llr_d;
  logic [BIT_N-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [SW-1:0]    stable_q, stable_d;
  logic [BIT_N-1:0] sum_w;

  llr_sat_add #(.BIT_N(BIT_N)) u_sat_add (
    .a   (llr_q),
    .b   (MSG_IN),
    .sum (sum_w)
  );

  always_comb begin
    state_d     = state_q;
    llr_d       = llr_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    iter_d      = iter_q;
    stable_d    = stable_q;
    if (start) begin
      llr_d    = LLR_CH;
      iter_d   = '0;
      stable_d = '0;
      state_d  = ST_RUN;
    end else if (state_q == ST_RUN && msg_valid) begin
      out_d       = sum_w;
      out_valid_d = 1'b1;
      iter_d      = iter_q + IW'(1);
      // The first update of a codeword has no valid predecessor decision
      if (iter_q != '0 && sum_w[BIT_N-1] == out_q[BIT_N-1]) begin
        stable_d = stable_q + SW'(1);
      end else begin
        stable_d = '0;
      end
      if (stable_d == SW'(STABLE_CNT - 1) || iter_d == IW'(MAX_ITER)) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      llr_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      iter_q      <= '0;
      stable_q    <= '0;
    end else if (en) begin
      state_q     <= state_d;
      llr_q       <= llr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      iter_q      <= iter_d;
      stable_q    <= stable_d;
    end
  end

  assign OUT       = out_q;
  assign out_valid = out_valid_q;
  assign hard_bit  = out_q[BIT_N-1];
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_bp_llr_update.sv
// Self-checking bench for bp_llr_update: single-update vector table, directed
// multi-cycle sequences, and randomized codewords against a behavioural model.
module tb_bp_llr_update;

  localparam int BIT_N      = 8;
  localparam int MAX_ITER   = 16;
  localparam int STABLE_CNT = 3;
  localparam int LIM        = 127;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             en        = 1'b0;
  logic             start     = 1'b0;
  logic             msg_valid = 1'b0;
  logic [BIT_N-1:0] LLR_CH    = '0;
  logic [BIT_N-1:0] MSG_IN    = '0;
  logic [BIT_N-1:0] OUT;
  logic             out_valid;
  logic             hard_bit;
  logic             busy;
  logic             done;
  logic [4:0]       iter_cnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int llr;
    int msg;
    int exp_out;
    int exp_hard;
  } vec_t;

  vec_t vecs[12];

  bp_llr_update #(
    .BIT_N      (BIT_N),
    .MAX_ITER   (MAX_ITER),
    .STABLE_CNT (STABLE_CNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .LLR_CH    (LLR_CH),
    .msg_valid (msg_valid),
    .MSG_IN    (MSG_IN),
    .OUT       (OUT),
    .out_valid (out_valid),
    .hard_bit  (hard_bit),
    .busy      (busy),
    .done      (done),
    .iter_cnt  (iter_cnt)
  );

  always #5 clk = ~clk;

  // Reference: clamp both operands into the symmetric range, add, clamp again
  function automatic int sat_model(input int a, input int b);
    int s;
    if (a < -LIM) a = -LIM;
    if (b < -LIM) b = -LIM;
    s = a + b;
    if (s > LIM) s = LIM;
    if (s < -LIM) s = -LIM;
    return s;
  endfunction

  function automatic int out_s();
    return int'($signed(OUT));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input int llr, input logic mv, input int msg);
    start     = s;
    LLR_CH    = llr[BIT_N-1:0];
    msg_valid = mv;
    MSG_IN    = msg[BIT_N-1:0];
    step();
    start     = 1'b0;
    msg_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input int e_out, input int e_hard,
                          input int e_ov, input int e_busy, input int e_done, input int e_iter);
    checkOutput({name, "/out"}, out_s(), e_out);
    checkOutput({name, "/hard"}, int'(hard_bit), e_hard);
    checkOutput({name, "/out_valid"}, int'(out_valid), e_ov);
    checkOutput({name, "/busy"}, int'(busy), e_busy);
    checkOutput({name, "/done"}, int'(done), e_done);
    checkOutput({name, "/iter"}, int'(iter_cnt), e_iter);
  endtask

  initial begin
    int m36[5];
    int e36[5];
    int hist[$];
    int llr;
    int msg;
    int exp_out;
    bit model_done;
    bit mv;

    vecs[0]  = '{100, 50, 127, 0};
    vecs[1]  = '{-128, -128, -127, 1};
    vecs[2]  = '{-20, 5, -15, 1};
    vecs[3]  = '{127, 127, 127, 0};
    vecs[4]  = '{-128, 0, -127, 1};
    vecs[5]  = '{0, 0, 0, 0};
    vecs[6]  = '{-1, 0, -1, 1};
    vecs[7]  = '{50, -50, 0, 0};
    vecs[8]  = '{-100, -100, -127, 1};
    vecs[9]  = '{127, -128, 0, 0};
    vecs[10] = '{-128, 127, 0, 0};
    vecs[11] = '{60, -61, -1, 1};

    // Reset state is visible without any clock edge
    #2;
    checkAll("reset", 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    en    = 1'b1;

    // Messages in IDLE are ignored
    applyStimulus(1'b0, 0, 1'b1, 50);
    checkAll("idle_msg", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].llr, 1'b0, 0);
      checkOutput($sformatf("vec%0d/start_busy", i), int'(busy), 1);
      checkOutput($sformatf("vec%0d/start_iter", i), int'(iter_cnt), 0);
      applyStimulus(1'b0, 0, 1'b1, vecs[i].msg);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_hard, 1, 1, 0, 1);
      applyStimulus(1'b0, 0, 1'b0, 0);
      checkOutput($sformatf("vec%0d/ov_drop", i), int'(out_valid), 0);
    end

    // Early stop after three equal hard decisions
    m36 = '{5, -30, 1, 2, 3};
    e36 = '{15, -20, 11, 12, 13};
    applyStimulus(1'b1, 10, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 0, 1'b1, m36[i]);
      checkAll($sformatf("stable%0d", i), e36[i], (e36[i] < 0) ? 1 : 0, 1,
               (i == 4) ? 0 : 1, (i == 4) ? 1 : 0, i + 1);
    end
    applyStimulus(1'b0, 0, 1'b1, 7);
    checkAll("done_ignore", 13, 0, 0, 0, 0, 5);

    // Alternating decisions run to the iteration limit
    applyStimulus(1'b1, 0, 1'b0, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 0, 1'b1, (i % 2 == 0) ? 1 : -1);
      checkOutput($sformatf("maxit%0d/out", i), out_s(), (i % 2 == 0) ? 1 : -1);
      checkOutput($sformatf("maxit%0d/done", i), int'(done), (i == 15) ? 1 : 0);
      checkOutput($sformatf("maxit%0d/iter", i), int'(iter_cnt), i + 1);
    end
    applyStimulus(1'b0, 0, 1'b0, 0);
    checkOutput("maxit/busy_after", int'(busy), 0);

    // Stall mid-run: everything frozen while en is low
    applyStimulus(1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 0, 1'b1, 5);
    applyStimulus(1'b0, 0, 1'b1, -5);
    applyStimulus(1'b0, 0, 1'b0, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 0, 1'b1, 9);
      checkAll($sformatf("stall%0d", i), -5, 1, 0, 1, 0, 2);
    end
    en = 1'b1;
    applyStimulus(1'b0, 0, 1'b1, 9);
    checkAll("stall_resume", 9, 0, 1, 1, 0, 3);

    // Asynchronous reset mid-run aborts without a done pulse
    applyStimulus(1'b1, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 0, 1'b1, (i % 2 == 0) ? 1 : -1);
    end
    checkOutput("prereset/iter", int'(iter_cnt), 4);
    rst_n = 1'b0;
    #1;
    checkAll("midreset", 0, 0, 0, 0, 0, 0);
    step();
    checkAll("midreset_hold", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 7, 1'b1, 40);
    checkAll("start_prio", 0, 0, 0, 1, 0, 0);
    applyStimulus(1'b0, 0, 1'b1, 3);
    checkAll("after_reset_upd", 10, 0, 1, 1, 0, 1);

    // Randomized codewords against the behavioural model
    for (int c = 0; c < 30; c++) begin
      case ($urandom_range(0, 9))
        0:       llr = -128;
        1:       llr = 127;
        default: llr = int'($urandom_range(0, 255)) - 128;
      endcase
      applyStimulus(1'b1, llr, 1'b0, 0);
      hist.delete();
      model_done = 1'b0;
      for (int cyc = 0; cyc < 40 && !model_done; cyc++) begin
        mv = ($urandom_range(0, 3) != 0);
        msg = ($urandom_range(0, 15) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
        applyStimulus(1'b0, 0, mv, msg);
        if (mv) begin
          exp_out = sat_model(llr, msg);
          hist.push_back((exp_out < 0) ? 1 : 0);
          model_done = (hist.size() == MAX_ITER) ||
                       (hist.size() >= STABLE_CNT &&
                        hist[hist.size()-1] == hist[hist.size()-2] &&
                        hist[hist.size()-2] == hist[hist.size()-3]);
          checkOutput($sformatf("rnd%0d.%0d/out", c, cyc), out_s(), exp_out);
          checkOutput($sformatf("rnd%0d.%0d/hard", c, cyc), int'(hard_bit), hist[hist.size()-1]);
          checkOutput($sformatf("rnd%0d.%0d/ov", c, cyc), int'(out_valid), 1);
          checkOutput($sformatf("rnd%0d.%0d/iter", c, cyc), int'(iter_cnt), hist.size());
          checkOutput($sformatf("rnd%0d.%0d/done", c, cyc), int'(done), int'(model_done));
        end else begin
          checkOutput($sformatf("rnd%0d.%0d/ov_idle", c, cyc), int'(out_valid), 0);
          checkOutput($sformatf("rnd%0d.%0d/done_idle", c, cyc), int'(done), 0);
        end
      end
      checkOutput($sformatf("rnd%0d/busy_end", c), int'(busy), model_done ? 0 : 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
